// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared states and byte codes for the UART packet controller
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GOT_CMD   = 3'd1,
    ST_GOT_ADDR  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_TX        = 3'd5
  } state_e;

  localparam logic [7:0] CMD_WRITE       = 8'h57;
  localparam logic [7:0] CMD_READ        = 8'h52;
  localparam logic [7:0] RSP_OK          = 8'h4B;
  localparam logic [7:0] RSP_DATA        = 8'h44;
  localparam logic [7:0] RSP_ERR         = 8'h45;
  localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
  localparam logic [7:0] ERR_BAD_ADDR    = 8'h02;

endpackage

// File: rtl/uart_resp_serializer.sv
// rtl/uart_resp_serializer.sv - streams a 1-3 byte response out under tx_ready flow control
module uart_resp_serializer
  import uart_pkt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [1:0] len,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       last
);

  logic [7:0] nxt0;
  logic [7:0] nxt1;
  logic [1:0] rem;

  // rem counts bytes still queued behind the one on tx_byte
  assign last = tx_valid && (rem == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_byte  <= 8'h00;
      nxt0     <= 8'h00;
      nxt1     <= 8'h00;
      rem      <= 2'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_byte  <= b0;
      nxt0     <= b1;
      nxt1     <= b2;
      rem      <= len - 2'd1;
    end else if (tx_valid && tx_ready) begin
      if (rem == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_byte <= nxt0;
        nxt0    <= nxt1;
        rem     <= rem - 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_pkt_ctrl.sv
// rtl/uart_pkt_ctrl.sv - 3-byte UART command packets to the register core and its responses back
// Optional partial-packet timeout is built only when PKT_TIMEOUT_EN is defined.
module uart_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       cmd_ready,
  output logic [7:0] cmd,
  output logic [7:0] addr,
  output logic [7:0] data,
  input  logic       resp_ok,
  input  logic       resp_data,
  input  logic       resp_err,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data_byte,
  input  logic [7:0] resp_err_code,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err
);

  logic [2:0] state;
  logic       ser_load;
  logic [7:0] ser_b0;
  logic [7:0] ser_b1;
  logic [7:0] ser_b2;
  logic [1:0] ser_len;
  logic       tx_last;
  logic       timeout_hit;

  assign busy      = !(state == ST_IDLE || state == ST_GOT_CMD || state == ST_GOT_ADDR);
  assign cmd_ready = (state == ST_ISSUE);
  assign ser_load  = (state == ST_WAIT_RESP) && (resp_ok || resp_data || resp_err);

`ifdef PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
  logic          frame_err_q;
  logic          partial;

  assign partial     = (state == ST_GOT_CMD) || (state == ST_GOT_ADDR);
  // a byte arriving in the expiry cycle wins over the timeout
  assign timeout_hit = partial && !rx_valid && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign frame_err   = frame_err_q;

  always_ff @(posedge clk) begin
    if (rst || !partial || rx_valid || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
    frame_err_q <= !rst && timeout_hit;
  end
`else
  assign timeout_hit = 1'b0;
  assign frame_err   = 1'b0;
`endif

  // err outranks data, data outranks ok
  always_comb begin
    ser_b0  = RSP_OK;
    ser_b1  = resp_addr;
    ser_b2  = 8'h00;
    ser_len = 2'd2;
    if (resp_err) begin
      ser_b0 = RSP_ERR;
      ser_b1 = resp_err_code;
    end else if (resp_data) begin
      ser_b0  = RSP_DATA;
      ser_b2  = resp_data_byte;
      ser_len = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cmd     <= 8'h00;
      addr    <= 8'h00;
      data    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      overrun <= rx_valid && busy;
      case (state)
        ST_IDLE: if (rx_valid) begin
          cmd   <= rx_byte;
          state <= ST_GOT_CMD;
        end
        ST_GOT_CMD: if (rx_valid) begin
          addr  <= rx_byte;
          state <= ST_GOT_ADDR;
        end else if (timeout_hit) begin
          state <= ST_IDLE;
        end
        ST_GOT_ADDR: if (rx_valid) begin
          data  <= rx_byte;
          state <= ST_ISSUE;
        end else if (timeout_hit) begin
          state <= ST_IDLE;
        end
        ST_ISSUE:     state <= ST_WAIT_RESP;
        ST_WAIT_RESP: if (ser_load) state <= ST_TX;
        ST_TX:        if (tx_valid && tx_ready && tx_last) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  uart_resp_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .b0       (ser_b0),
    .b1       (ser_b1),
    .b2       (ser_b2),
    .len      (ser_len),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .last     (tx_last)
  );

endmodule
